sudoku_solver_core: RTL
=======================

Name: sudoku_solver_core

Overview:
- Parametrised backtracking Sudoku solver for any grid order ORD (grid side LEN=ORD*ORD, AREA=LEN*LEN cells).
- Generalises the fixed-size token-chain grid with four additions:
  - pre-loaded givens through a load handshake;
  - fixed-cell skipping during search;
  - a cycle budget with a timeout outcome;
  - a registered readout port for the solved grid.
- Sits between the host/test harness and the solution display logic.

Parameters:
- ORD, 3, grid order; LEN=ORD*ORD, AREA=LEN*LEN.
- CNT_W, 32, width of cycle counter.
- MAX_CYCLES, 0, RUN-cycle budget; 0 disables timeout.

Ports:
- clock  in  1  clock; all logic is posedge.
- reset  in  1  synchronous, active-high; clears all state.
- ld_valid  in  1  load request for one given.
- ld_ready  out  1  load accepted this cycle when ld_valid&&ld_ready.
- ld_index  in  IDX_W=$clog2(AREA)  cell index, row-major.
- ld_value  in  VAL_W=$clog2(LEN+1)  binary value 1..LEN; 0 clears the cell.
- start  in  1  begin solving.
- busy  out  1  high in CHECK or RUN.
- done  out  1  high in SUCCESS, FAILURE or TIMEOUT.
- success  out  1  high only in SUCCESS.
- timeout  out  1  high only in TIMEOUT.
- cycles  out  CNT_W  number of RUN cycles consumed; saturates at all-ones.
- rd_index  in  IDX_W  readout cell select.
- rd_value  out  VAL_W  binary value of rd_index cell, one cycle latency.

Behaviour:
- Reset values:
  - state=IDLE; all cells value 0, fixed=0.
  - ld_ready=1, busy=0, done=0, success=0, timeout=0, cycles=0, rd_value=0.
- Cell storage: one-hot LEN-bit value plus a fixed bit per cell.
  - Row, column and block occupancy masks are OR-reductions of the one-hot values.
  - Block index = (r/ORD)*ORD + c/ORD.
- States:
  - IDLE:
    - ld_ready=1.
    - An accepted load writes the cell and sets fixed = (ld_value!=0).
    - ld_index>=AREA or ld_value>LEN: ignored but still accepted.
    - start → CHECK. If start and a load arrive together, the load is applied first and is visible to CHECK.
  - CHECK (1 cycle):
    - If any two fixed cells share a value in a row, column or block → FAILURE.
    - Else clear all non-fixed cells, cursor=0, dir=FWD, cycles=0 → RUN.
  - RUN: one cursor step per cycle; cycles increments every RUN cycle.
    - Fixed cell at cursor: advance cursor in dir with no value change.
    - Non-fixed cell: pick the lowest value strictly above its current value that is not in the row|col|blk mask (own value excluded).
      - Found: write it, dir=FWD, cursor+1.
      - None: clear cell to 0, dir=BAK, cursor-1.
    - Cursor stepping past AREA-1 forward → SUCCESS.
    - Cursor stepping below 0 backward → FAILURE.
    - If MAX_CYCLES!=0 and cycles reaches MAX_CYCLES before either outcome → TIMEOUT. The MAX_CYCLES-th step's write is still committed.
  - SUCCESS/FAILURE/TIMEOUT:
    - Sticky; ld_ready=1.
    - A load returns to IDLE and applies that write.
    - start → CHECK (re-solve with current fixed cells).
    - Grid contents are held for readout.
- ld_ready=0 in CHECK and RUN; loads are dropped there.
- start is ignored in CHECK and RUN.
- Readout: rd_value registered from the one-hot→binary encode of cell rd_index; valid in every state. rd_index>=AREA returns 0.
- Reset asserted mid-RUN: next cycle state=IDLE, all cells and givens cleared.
- Worst case: RUN is exponential in free cells; the timeout is the only bound.

Decomposition:
- Package sudoku_pkg:
  - ORD-derived localparam functions for LEN, AREA, IDX_W, VAL_W;
  - blockof(r,c);
  - onehot_to_bin and bin_to_onehot functions;
  - state enum {IDLE, CHECK, RUN, SUCCESS, FAILURE, TIMEOUT}.
- Sub-module solver_cell (per cell):
  - holds value/fixed;
  - computes next-candidate one-hot from current value and exclusion mask via priority pick above current;
  - reports found/none.
- Top module owns the FSM, cursor, counter, conflict check and readout.

Test Plan:
- ORD=2, no givens, start:
  - SUCCESS, no backtracking, cycles=16;
  - rows read 1 2 3 4 / 3 4 1 2 / 2 1 4 3 / 4 3 2 1.
- ORD=2, givens idx0=1 and idx1=1, start:
  - CHECK → FAILURE on the 2nd cycle after start;
  - done=1, success=0, cycles=0.
- ORD=2, given idx5=1 (row1,col1), start:
  - SUCCESS with idx5 still 1;
  - every row, column and block is a permutation of 1..4;
  - cycles > 16 (backtracking exercised).
- ORD=2, MAX_CYCLES=5, no givens:
  - TIMEOUT after exactly 5 RUN cycles, cycles=5;
  - rd cells 0..4 = 1,2,3,4,3.
- ORD=3, standard 30-given puzzle:
  - SUCCESS matching the known solution;
  - givens unchanged; ld_ready=0 and attempted loads dropped throughout RUN.
- Reset asserted mid-RUN for one cycle:
  - next cycle IDLE, all rd_value=0, cycles=0;
  - a fresh solve reproduces the first test's result.

Source files
------------

// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared sizing functions, FSM states and value encoders for the Sudoku solver
package sudoku_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, RUN, SUCCESS, FAILURE, TIMEOUT} state_t;

    // Widest one-hot value the encoders handle (ORD up to 8).
    localparam int MAX_LEN = 64;

    function automatic int len_of(input int ord);
        return ord * ord;
    endfunction

    function automatic int area_of(input int ord);
        return ord * ord * ord * ord;
    endfunction

    function automatic int idx_w_of(input int ord);
        return $clog2(area_of(ord));
    endfunction

    function automatic int val_w_of(input int ord);
        return $clog2(len_of(ord) + 1);
    endfunction

    function automatic int blockof(input int ord, input int r, input int c);
        return (r / ord) * ord + c / ord;
    endfunction

    function automatic int onehot_to_bin(input logic [MAX_LEN-1:0] oh);
        int v;
        v = 0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (oh[i]) v = i + 1;
        end
        return v;
    endfunction

    function automatic logic [MAX_LEN-1:0] bin_to_onehot(input int v);
        if (v <= 0 || v > MAX_LEN) return '0;
        return MAX_LEN'(1) << (v - 1);
    endfunction

endpackage

// File: rtl/sudoku_solver_core_cell.sv
// rtl/sudoku_solver_core_cell.sv - one grid cell: one-hot value, fixed flag, next-candidate pick
module solver_cell
    import sudoku_pkg::*;
#(
    parameter int LEN = 9
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           i_ld_we,
    input  logic [LEN-1:0] i_ld_value,
    input  logic           i_clr_free,
    input  logic           i_step_we,
    input  logic [LEN-1:0] i_excl,
    output logic [LEN-1:0] o_value,
    output logic           o_fixed,
    output logic [LEN-1:0] o_next,
    output logic           o_found
);

    logic [LEN-1:0] r_value;
    logic           r_fixed;
    logic           w_seen;

    // Lowest free value strictly above the current one; an empty cell starts from 1.
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        w_seen  = (r_value == '0);
        for (int i = 0; i < LEN; i++) begin
            if (w_seen && !i_excl[i] && !o_found) begin
                o_next[i] = 1'b1;
                o_found   = 1'b1;
            end
            if (r_value[i]) w_seen = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_value <= '0;
            r_fixed <= 1'b0;
        end else if (i_ld_we) begin
            r_value <= i_ld_value;
            r_fixed <= (i_ld_value != '0);
        end else if (i_clr_free && !r_fixed) begin
            r_value <= '0;
        end else if (i_step_we && !r_fixed) begin
            r_value <= o_next;
        end
    end

    assign o_value = r_value;
    assign o_fixed = r_fixed;

endmodule

// File: rtl/sudoku_solver_core.sv
// rtl/sudoku_solver_core.sv - backtracking Sudoku solver with givens, cycle budget and readout
module sudoku_solver_core
    import sudoku_pkg::*;
#(
    parameter int          ORD        = 3,
    parameter int          CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 0,
    localparam int LEN   = len_of(ORD),
    localparam int AREA  = area_of(ORD),
    localparam int IDX_W = idx_w_of(ORD),
    localparam int VAL_W = val_w_of(ORD)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_ld_valid,
    output logic             o_ld_ready,
    input  logic [IDX_W-1:0] i_ld_index,
    input  logic [VAL_W-1:0] i_ld_value,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_success,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycles,
    input  logic [IDX_W-1:0] i_rd_index,
    output logic [VAL_W-1:0] o_rd_value
);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_cursor, w_cursor_nxt;
    logic             r_dir_bak, w_dir_nxt;
    logic [CNT_W-1:0] r_cycles, w_cycles_nxt, w_cyc_inc;
    logic [VAL_W-1:0] r_rd_value;

    logic [LEN-1:0]   w_val  [AREA];
    logic [LEN-1:0]   w_next [AREA];
    logic [AREA-1:0]  w_fixed;
    logic [AREA-1:0]  w_found;
    logic [LEN-1:0]   w_fr [LEN];
    logic [LEN-1:0]   w_fc [LEN];
    logic [LEN-1:0]   w_fb [LEN];
    logic [LEN-1:0]   w_excl;
    logic [LEN-1:0]   w_ld_oh;
    logic             w_conflict;
    logic             w_ld_fire;
    logic             w_ld_ok;
    logic             w_clr_free;
    logic             w_fwd;

    assign w_ld_fire  = i_ld_valid && o_ld_ready;
    assign w_ld_ok    = w_ld_fire && (int'(i_ld_index) < AREA) && (int'(i_ld_value) <= LEN);
    assign w_ld_oh    = LEN'(bin_to_onehot(int'(i_ld_value)));
    assign w_clr_free = (r_state == CHECK) && !w_conflict;

    for (genvar g = 0; g < AREA; g++) begin : g_cell
        solver_cell #(.LEN(LEN)) u_cell (
            .clock      (clock),
            .reset      (reset),
            .i_ld_we    (w_ld_ok && (int'(i_ld_index) == g)),
            .i_ld_value (w_ld_oh),
            .i_clr_free (w_clr_free),
            .i_step_we  ((r_state == RUN) && (int'(r_cursor) == g)),
            .i_excl     (w_excl),
            .o_value    (w_val[g]),
            .o_fixed    (w_fixed[g]),
            .o_next     (w_next[g]),
            .o_found    (w_found[g])
        );
    end

    // Givens conflict: a fixed value already seen in the same row/col/block.
    // Exclusion mask: everything sharing a unit with the cursor cell except itself.
    always_comb begin
        automatic int cr = int'(r_cursor) / LEN;
        automatic int cc = int'(r_cursor) % LEN;
        automatic int cb = blockof(ORD, cr, cc);
        w_excl     = '0;
        w_conflict = 1'b0;
        for (int u = 0; u < LEN; u++) begin
            w_fr[u] = '0;
            w_fc[u] = '0;
            w_fb[u] = '0;
        end
        for (int i = 0; i < AREA; i++) begin
            automatic int             r  = i / LEN;
            automatic int             c  = i % LEN;
            automatic int             b  = blockof(ORD, r, c);
            automatic logic [LEN-1:0] fv = w_fixed[i] ? w_val[i] : '0;
            if ((fv & (w_fr[r] | w_fc[c] | w_fb[b])) != '0) w_conflict = 1'b1;
            w_fr[r] = w_fr[r] | fv;
            w_fc[c] = w_fc[c] | fv;
            w_fb[b] = w_fb[b] | fv;
            if ((r == cr || c == cc || b == cb) && i != int'(r_cursor)) w_excl = w_excl | w_val[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cursor  <= '0;
            r_dir_bak <= 1'b0;
            r_cycles  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cursor  <= w_cursor_nxt;
            r_dir_bak <= w_dir_nxt;
            r_cycles  <= w_cycles_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cursor_nxt = r_cursor;
        w_dir_nxt    = r_dir_bak;
        w_cycles_nxt = r_cycles;
        w_cyc_inc    = (r_cycles == '1) ? r_cycles : r_cycles + CNT_W'(1);
        w_fwd        = w_fixed[r_cursor] ? !r_dir_bak : w_found[r_cursor];
        case (r_state)
            IDLE, SUCCESS, FAILURE, TIMEOUT: begin
                if (i_start)        w_state_nxt = CHECK;
                else if (w_ld_fire) w_state_nxt = IDLE;
            end
            CHECK: begin
                w_cycles_nxt = '0;
                if (w_conflict) begin
                    w_state_nxt = FAILURE;
                end else begin
                    w_state_nxt  = RUN;
                    w_cursor_nxt = '0;
                    w_dir_nxt    = 1'b0;
                end
            end
            RUN: begin
                w_cycles_nxt = w_cyc_inc;
                w_dir_nxt    = !w_fwd;
                if (w_fwd) begin
                    if (int'(r_cursor) == AREA - 1) w_state_nxt = SUCCESS;
                    else                            w_cursor_nxt = r_cursor + IDX_W'(1);
                end else begin
                    if (r_cursor == '0) w_state_nxt = FAILURE;
                    else                w_cursor_nxt = r_cursor - IDX_W'(1);
                end
                if (MAX_CYCLES != 0 && w_state_nxt == RUN && w_cyc_inc >= CNT_W'(MAX_CYCLES))
                    w_state_nxt = TIMEOUT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_value <= '0;
        end else if (int'(i_rd_index) < AREA) begin
            r_rd_value <= VAL_W'(onehot_to_bin(MAX_LEN'(w_val[i_rd_index])));
        end else begin
            r_rd_value <= '0;
        end
    end

    assign o_ld_ready = !(r_state == CHECK || r_state == RUN);
    assign o_busy     = (r_state == CHECK || r_state == RUN);
    assign o_done     = (r_state == SUCCESS || r_state == FAILURE || r_state == TIMEOUT);
    assign o_success  = (r_state == SUCCESS);
    assign o_timeout  = (r_state == TIMEOUT);
    assign o_cycles   = r_cycles;
    assign o_rd_value = r_rd_value;

endmodule
